// File: rtl/vec_strided_store_pkg.sv
// Shared definitions for the vector strided load/store engines:
// element-width encodings, engine state encoding and strobe/mask helpers.
package vec_strided_store_pkg;

   localparam logic [2:0] VSEW_E8  = 3'd0;
   localparam logic [2:0] VSEW_E16 = 3'd1;
   localparam logic [2:0] VSEW_E32 = 3'd2;

   // Encodings are fixed so the load engine can share them in debug views.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_RD    = 3'd2,
      ST_CAP   = 3'd3,
      ST_WR    = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   // Byte strobe for an element sitting in lane 0; zero for illegal widths.
   function automatic logic [3:0] strb_base(input logic [2:0] vsew);
      case (vsew)
         VSEW_E8:  return 4'h1;
         VSEW_E16: return 4'h3;
         VSEW_E32: return 4'hF;
         default:  return 4'h0;
      endcase
   endfunction

   // Bit mask covering one element of the given width.
   function automatic logic [31:0] elem_mask(input logic [2:0] vsew);
      case (vsew)
         VSEW_E8:  return 32'h0000_00FF;
         VSEW_E16: return 32'h0000_FFFF;
         VSEW_E32: return 32'hFFFF_FFFF;
         default:  return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic vsew_legal(input logic [2:0] vsew);
      return (vsew <= VSEW_E32);
   endfunction

endpackage

// File: rtl/vec_strided_store_if.sv
// Bundle of command, status, VRF-read and memory-write signals of the
// strided-store engine. master = engine side, slave = decode/VRF/responder side.
interface vec_strided_store_if #(
   parameter int VL_W   = 6,
   parameter int WIDX_W = 4
);
   logic              start;
   logic [31:0]       base;
   logic [31:0]       stride;
   logic [VL_W-1:0]   vl;
   logic [2:0]        vsew;
   logic [4:0]        vs3;

   logic              busy;
   logic              done;
   logic              err;

   logic              vrf_ren;
   logic [4:0]        vrf_rsel;
   logic [WIDX_W-1:0] vrf_widx;
   logic [31:0]       vrf_rdata;

   logic              mem_valid;
   logic              mem_ready;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;

   modport master (
      input  start, base, stride, vl, vsew, vs3, vrf_rdata, mem_ready,
      output busy, done, err, vrf_ren, vrf_rsel, vrf_widx,
             mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output start, base, stride, vl, vsew, vs3, vrf_rdata, mem_ready,
      input  busy, done, err, vrf_ren, vrf_rsel, vrf_widx,
             mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/vec_strided_store_elem_lane.sv
// Pulls one element out of a packed VRF word and places it on the byte
// lane selected by the target address, with matching byte strobes.
// Purely combinational; the load path can use the same shifts inverted.
module vec_strided_store_elem_lane
   import vec_strided_store_pkg::*;
(
   input  logic [2:0]  vsew_i,
   input  logic [1:0]  elem_off_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o
);

   logic [31:0] elem;

   // Extract at the element's byte offset, then re-place at the address lane.
   always_comb begin
      elem    = (rdata_i >> {elem_off_i, 3'b000}) & elem_mask(vsew_i);
      wdata_o = elem << {lane_i, 3'b000};
      wstrb_o = strb_base(vsew_i) << lane_i;
   end

endmodule

// File: rtl/vec_strided_store.sv
// Strided vector store engine: walks vl elements of register vs3, issuing
// one byte-strobed word write per element at base + i*stride.
//
// state  | meaning
// IDLE   | waiting for start; command is latched on start
// CHECK  | element-count, width and alignment checks for element i
// RD     | VRF read of the word holding element i
// CAP    | element captured from VRF data, memory request built
// WR     | request held until the responder accepts it
// FIN    | one-cycle done/err pulse, then back to IDLE
module vec_strided_store
   import vec_strided_store_pkg::*;
#(
   parameter int VL_W   = 6,
   parameter int WIDX_W = 4
) (
   input logic                 clk_i,
   input logic                 rst_i,
   vec_strided_store_if.master bus
);

   state_t            state_q, state_d;
   logic [VL_W-1:0]   i_q, i_d;
   logic [31:0]       cur_addr_q, cur_addr_d;
   logic [31:0]       stride_q, stride_d;
   logic [VL_W-1:0]   vl_q, vl_d;
   logic [2:0]        vsew_q, vsew_d;
   logic [4:0]        vs3_q, vs3_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              vrf_ren_q, vrf_ren_d;
   logic [WIDX_W-1:0] widx_q, widx_d;
   logic              mem_valid_q, mem_valid_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;

   logic [31:0]       byte_off;
   logic              misalign;
   logic [31:0]       lane_wdata;
   logic [3:0]        lane_wstrb;

   // Byte offset of element i inside the source register; only meaningful
   // for legal widths, which CHECK guarantees before RD/CAP use it.
   always_comb begin
      byte_off = 32'(i_q) << vsew_q[1:0];
      misalign = ((vsew_q == VSEW_E16) && cur_addr_q[0]) ||
                 ((vsew_q == VSEW_E32) && (cur_addr_q[1:0] != 2'b00));
   end

   vec_strided_store_elem_lane u_lane (
      .vsew_i     (vsew_q),
      .elem_off_i (byte_off[1:0]),
      .lane_i     (cur_addr_q[1:0]),
      .rdata_i    (bus.vrf_rdata),
      .wdata_o    (lane_wdata),
      .wstrb_o    (lane_wstrb)
   );

   // Next-state and next-output logic; one-cycle strobes default low.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      cur_addr_d  = cur_addr_q;
      stride_d    = stride_q;
      vl_d        = vl_q;
      vsew_d      = vsew_q;
      vs3_d       = vs3_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      vrf_ren_d   = 1'b0;
      widx_d      = widx_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               i_d        = '0;
               cur_addr_d = bus.base;
               stride_d   = bus.stride;
               vl_d       = bus.vl;
               vsew_d     = bus.vsew;
               vs3_d      = bus.vs3;
               busy_d     = 1'b1;
               state_d    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!vsew_legal(vsew_q)) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else if (i_q == vl_q) begin
               done_d  = 1'b1;
               state_d = ST_FIN;
            end else if (misalign) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               vrf_ren_d = 1'b1;
               widx_d    = WIDX_W'(byte_off >> 2);
               state_d   = ST_RD;
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            mem_valid_d = 1'b1;
            mem_addr_d  = {cur_addr_q[31:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_wstrb_d = lane_wstrb;
            state_d     = ST_WR;
         end
         ST_WR: begin
            if (mem_valid_q && bus.mem_ready) begin
               mem_valid_d = 1'b0;
               i_d         = i_q + VL_W'(1);
               cur_addr_d  = cur_addr_q + stride_q;
               state_d     = ST_CHECK;
            end
         end
         ST_FIN: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d      = 1'b0;
            mem_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         cur_addr_q  <= '0;
         stride_q    <= '0;
         vl_q        <= '0;
         vsew_q      <= '0;
         vs3_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         vrf_ren_q   <= 1'b0;
         widx_q      <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         cur_addr_q  <= cur_addr_d;
         stride_q    <= stride_d;
         vl_q        <= vl_d;
         vsew_q      <= vsew_d;
         vs3_q       <= vs3_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         vrf_ren_q   <= vrf_ren_d;
         widx_q      <= widx_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.vrf_ren   = vrf_ren_q;
   assign bus.vrf_rsel  = vs3_q;
   assign bus.vrf_widx  = widx_q;
   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: doc/vec_strided_store.md
Name: vec_strided_store

Overview:
- Strided-store engine for the vector coprocessor (vsse.v). It is the write-direction counterpart of the strided-load path.
- It takes base, stride, vl, SEW and the source register vs3 from the PCPI decode. It reads packed elements from the vector register file and issues one byte-strobed word write per element on the coprocessor memory port (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb).
- It sits between the vector decode FSM and the shared memory responder.

Parameters:
- VL_W, 6, width of vl (max vl = 2^VL_W - 1)
- WIDX_W, 4, width of word index into one vector register (32-bit words)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  32  byte address of element 0 (cpu rs1)
- stride  in  32  signed byte stride (cpu rs2), two's complement
- vl  in  VL_W  element count
- vsew  in  3  0=e8, 1=e16, 2=e32, others illegal
- vs3  in  5  source vector register
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = aborted (illegal vsew or misaligned element)
- vrf_ren  out  1  VRF read enable
- vrf_rsel  out  5  VRF register select (= vs3)
- vrf_widx  out  WIDX_W  word index within register
- vrf_rdata  in  32  read data, valid the cycle after vrf_ren
- mem_valid  out  1  write request
- mem_ready  in  1  responder accept
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes, never 0 while mem_valid

Behaviour:
- Reset (async, immediate): state IDLE; busy=done=err=vrf_ren=mem_valid=0; mem_addr=mem_wdata=0; mem_wstrb=0. Reset during a write drops mem_valid the same instant; a partially completed store is not resumed.
- Registered outputs: no combinational path from inputs to any output.
- States: IDLE, CHECK, RD, CAP, WR, FIN.
- IDLE: on start, latch base/stride/vl/vsew/vs3; set elem index i=0, cur_addr=base; go to CHECK. start in any other state is ignored.
- CHECK: if vsew>2, go to FIN with err=1. If i==vl (includes vl=0), go to FIN with err=0. If the element is misaligned, go to FIN with err=1. Misaligned means: e16 with cur_addr[0]!=0, or e32 with cur_addr[1:0]!=0. Otherwise go to RD.
- RD: vrf_ren=1 for exactly this cycle, with vrf_rsel=vs3 and vrf_widx=(i<<vsew)>>2; go to CAP.
- CAP: extract the element from vrf_rdata at bit offset ((i<<vsew)&3)*8, width 8<<vsew. Shift it into mem_wdata at byte lane cur_addr[1:0]; other lanes are 0. Set mem_wstrb = ({1,3,F}[vsew]) << cur_addr[1:0], mem_addr = {cur_addr[31:2],2'b00}, mem_valid=1. Go to WR.
- WR: hold mem_valid/addr/wdata/wstrb stable until the cycle where mem_valid && mem_ready. In that cycle: mem_valid<=0, i<=i+1, cur_addr<=cur_addr+stride (mod 2^32, wrap allowed), go to CHECK. mem_ready while mem_valid=0 is ignored.
- FIN: done=1 and err as determined, for one cycle. busy<=0, then IDLE. start is accepted again in the next IDLE cycle.
- Cycle cost: 4 + responder latency per element, plus 2 (CHECK + FIN) overhead; vl=0 gives done 2 cycles after start.
- An error aborts the store. Elements already written stay written. No write is issued for the offending element.
- stride=0: every element is written to the same address; the last one wins.

Decomposition:
- Shared package vec_pkg: VSEW_E8/E16/E32 encodings, the strobe-base lookup, and state encoding constants (shared with the load engine).
- One natural sub-module, vec_elem_lane: combinational extract-from-word and place-into-lane plus strobe generation (vsew, elem offset, addr[1:0] -> wdata, wstrb). It is reusable by the load path in the inverse direction.

Test Plan:
- e16, vl=4, base=440, stride=8; vs3 words 0x00020001, 0x00040003 -> writes (440,0x00000001,0011), (448,0x00000002,0011), (456,0x00000003,0011), (464,0x00000004,0011); then done=1, err=0.
- e16, vl=2, base=440, stride=6; same data -> (440,0x00000001,0011), (444,0x00020000,1100); done, err=0.
- e8, vl=3, base=403, stride=-1; word 0x00CCBBAA -> (400,0xAA000000,1000), (400,0x00BB0000,0100), (400,0x0000CC00,0010).
- e32, vl=2, base=402 -> no mem_valid ever; done=1 with err=1 two cycles after start. vsew=3 gives the same result. vl=0 -> done, err=0, no writes.
- Responder delays mem_ready 3 cycles -> addr/wdata/wstrb stable throughout; start pulsed while busy -> ignored.
- Assert reset while mem_valid=1 -> mem_valid, busy, wstrb = 0 immediately. After release, a fresh start runs normally from element 0.
